// File: rtl/id_pkg.sv
// Shared decode constants for the RV32 ID stage: opcodes, ALU/shift op codes
// and bit positions inside the decode bundle.
package id_pkg;

  localparam int DCR_W = 24;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_SLT  = 3'd2;
  localparam logic [2:0] ALU_SLTU = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_AND  = 3'd6;

  localparam logic [1:0] SFT_SLL = 2'd0;
  localparam logic [1:0] SFT_SRL = 2'd1;
  localparam logic [1:0] SFT_SRA = 2'd2;

  localparam int D_AUIPC   = 23;
  localparam int D_F3_LSB  = 20;
  localparam int D_R       = 19;
  localparam int D_ICS     = 18;
  localparam int D_IL      = 17;
  localparam int D_JALR    = 16;
  localparam int D_S       = 15;
  localparam int D_U       = 14;
  localparam int D_B       = 13;
  localparam int D_J       = 12;
  localparam int D_MULDIV  = 11;
  localparam int D_ILLEGAL = 10;
  localparam int D_SHIFT   = 9;
  localparam int D_ALU_LSB = 6;
  localparam int D_SFT_LSB = 4;
  localparam int D_WRD     = 3;
  localparam int D_USE1    = 2;
  localparam int D_USE2    = 1;
  localparam int D_LUI     = 0;

  function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
    logic [2:0] op;
    case (f3)
      3'b000:  op = sub ? ALU_SUB : ALU_ADD;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Operand forwarding for one register source: lowest-index matching source
// wins, falling back to the regfile; x0 always reads zero.
module id_fwd_mux #(
  parameter int XLEN = 32,
  parameter int NFWD = 3
) (
  input  logic [4:0]           rs,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [5*NFWD-1:0]    fwd_rd,
  input  logic [XLEN*NFWD-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_pending,
  input  logic [XLEN-1:0]      rf_rdata,
  output logic [XLEN-1:0]      data,
  output logic                 pending_hit
);

  // Scan oldest to youngest so the youngest match overwrites the older ones.
  always_comb begin
    data        = rf_rdata;
    pending_hit = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd[5*i +: 5] == rs)) begin
        data        = fwd_data[XLEN*i +: XLEN];
        pending_hit = fwd_pending[i];
      end
    end
    if (rs == 5'd0) begin
      data        = '0;
      pending_hit = 1'b0;
    end
  end

endmodule

// File: rtl/stage_id_hs.sv
// RV32 instruction-decode stage with valid/ready handshakes, load-use stall
// and operand forwarding. Define RV32M_EN to accept the RV32M encodings.
module stage_id_hs
  import id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NFWD  = 3,
  parameter int DCR_W = id_pkg::DCR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 flush,
  output logic [4:0]           rf_raddr1,
  output logic [4:0]           rf_raddr2,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [5*NFWD-1:0]    fwd_rd,
  input  logic [XLEN*NFWD-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_pending,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_rr1,
  output logic [XLEN-1:0]      out_rr2,
  output logic [4:0]           out_rd,
  output logic [XLEN-1:0]      out_imm,
  output logic [XLEN-1:0]      out_target,
  output logic [DCR_W-1:0]     out_dcr
);

  logic [6:0]       opc;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [XLEN-1:0]  rr1, rr2;
  logic             ph1, ph2, stall;
  logic [XLEN-1:0]  imm_dec;
  logic [DCR_W-1:0] dcr_dec;
  logic             is_jalr, illegal;
  logic [4:0]       rd_dec;
  logic [XLEN-1:0]  tgt_sum;

  assign opc       = in_inst[6:0];
  assign f3        = in_inst[14:12];
  assign f7        = in_inst[31:25];
  assign rf_raddr1 = in_inst[19:15];
  assign rf_raddr2 = in_inst[24:20];

  id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd1 (
    .rs(rf_raddr1), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .fwd_pending(fwd_pending), .rf_rdata(rf_rdata1), .data(rr1), .pending_hit(ph1)
  );

  id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd2 (
    .rs(rf_raddr2), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .fwd_pending(fwd_pending), .rf_rdata(rf_rdata2), .data(rr2), .pending_hit(ph2)
  );

  // Stage p0: combinational decode of the instruction offered by IF.
  always_comb begin
    dcr_dec = '0;
    imm_dec = '0;
    is_jalr = 1'b0;
    illegal = 1'b0;
    case (opc)
      OPC_OP: begin
        if (f7 == F7_MULDIV) begin
`ifdef RV32M_EN
          dcr_dec[D_R]                = 1'b1;
          dcr_dec[D_MULDIV]           = 1'b1;
          dcr_dec[D_F3_LSB +: 3]      = f3;
          dcr_dec[D_WRD]              = 1'b1;
          dcr_dec[D_USE1]             = 1'b1;
          dcr_dec[D_USE2]             = 1'b1;
`else
          illegal = 1'b1;
`endif
        end else if ((f7 == F7_BASE) ||
                     ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))) begin
          dcr_dec[D_R]                = 1'b1;
          dcr_dec[D_F3_LSB +: 3]      = f3;
          dcr_dec[D_ALU_LSB +: 3]     = alu_op(f3, f7[5]);
          dcr_dec[D_WRD]              = 1'b1;
          dcr_dec[D_USE1]             = 1'b1;
          dcr_dec[D_USE2]             = 1'b1;
          if (f3 == 3'b001) begin
            dcr_dec[D_SHIFT]          = 1'b1;
            dcr_dec[D_SFT_LSB +: 2]   = SFT_SLL;
          end else if (f3 == 3'b101) begin
            dcr_dec[D_SHIFT]          = 1'b1;
            dcr_dec[D_SFT_LSB +: 2]   = f7[5] ? SFT_SRA : SFT_SRL;
          end
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dcr_dec[D_ICS]            = 1'b1;
        dcr_dec[D_F3_LSB +: 3]    = f3;
        dcr_dec[D_ALU_LSB +: 3]   = alu_op(f3, 1'b0);
        dcr_dec[D_WRD]            = 1'b1;
        dcr_dec[D_USE1]           = 1'b1;
        imm_dec = {{20{in_inst[31]}}, in_inst[31:20]};
        if (f3 == 3'b001) begin
          dcr_dec[D_SHIFT]        = 1'b1;
          dcr_dec[D_SFT_LSB +: 2] = SFT_SLL;
          illegal = (f7 != F7_BASE);
        end else if (f3 == 3'b101) begin
          dcr_dec[D_SHIFT]        = 1'b1;
          dcr_dec[D_SFT_LSB +: 2] = f7[5] ? SFT_SRA : SFT_SRL;
          illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
        end
      end
      OPC_LOAD: begin
        dcr_dec[D_IL]          = 1'b1;
        dcr_dec[D_F3_LSB +: 3] = f3;
        dcr_dec[D_WRD]         = 1'b1;
        dcr_dec[D_USE1]        = 1'b1;
        imm_dec = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_STORE: begin
        dcr_dec[D_S]           = 1'b1;
        dcr_dec[D_F3_LSB +: 3] = f3;
        dcr_dec[D_USE1]        = 1'b1;
        dcr_dec[D_USE2]        = 1'b1;
        imm_dec = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OPC_BRANCH: begin
        dcr_dec[D_B]           = 1'b1;
        dcr_dec[D_F3_LSB +: 3] = f3;
        dcr_dec[D_USE1]        = 1'b1;
        dcr_dec[D_USE2]        = 1'b1;
        case (f3[2:1])
          2'b00:   dcr_dec[D_ALU_LSB +: 3] = ALU_SUB;
          2'b10:   dcr_dec[D_ALU_LSB +: 3] = ALU_SLT;
          2'b11:   dcr_dec[D_ALU_LSB +: 3] = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
        imm_dec = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
      end
      OPC_JALR: begin
        dcr_dec[D_JALR]        = 1'b1;
        dcr_dec[D_F3_LSB +: 3] = f3;
        dcr_dec[D_WRD]         = 1'b1;
        dcr_dec[D_USE1]        = 1'b1;
        is_jalr = 1'b1;
        imm_dec = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_JAL: begin
        dcr_dec[D_J]   = 1'b1;
        dcr_dec[D_WRD] = 1'b1;
        imm_dec = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
      end
      OPC_LUI: begin
        dcr_dec[D_U]   = 1'b1;
        dcr_dec[D_WRD] = 1'b1;
        dcr_dec[D_LUI] = 1'b1;
        imm_dec = {in_inst[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        dcr_dec[D_U]     = 1'b1;
        dcr_dec[D_WRD]   = 1'b1;
        dcr_dec[D_AUIPC] = 1'b1;
        imm_dec = {in_inst[31:12], 12'b0};
      end
      // FENCE and SYSTEM are legal but carry no format class or register use.
      OPC_MISC_MEM, OPC_SYSTEM: begin
        dcr_dec[D_F3_LSB +: 3] = f3;
        imm_dec = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      dcr_dec            = '0;
      dcr_dec[D_ILLEGAL] = 1'b1;
      imm_dec            = '0;
      is_jalr            = 1'b0;
    end
  end

  assign rd_dec   = dcr_dec[D_WRD] ? in_inst[11:7] : 5'd0;
  assign tgt_sum  = is_jalr ? (rr1 + imm_dec) : (in_pc + imm_dec);
  assign stall    = in_valid & ((ph1 & dcr_dec[D_USE1]) | (ph2 & dcr_dec[D_USE2]));

  logic             vld_p1;
  logic [XLEN-1:0]  pc_p1, rr1_p1, rr2_p1, imm_p1, tgt_p1;
  logic [4:0]       rd_p1;
  logic [DCR_W-1:0] dcr_p1;

  assign in_ready = (~vld_p1 | out_ready) & ~stall;

  // Stage p1: decode bundle register toward EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      pc_p1  <= '0;
      rr1_p1 <= '0;
      rr2_p1 <= '0;
      rd_p1  <= '0;
      imm_p1 <= '0;
      tgt_p1 <= '0;
      dcr_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (in_valid && in_ready) begin
      vld_p1 <= 1'b1;
      pc_p1  <= in_pc;
      rr1_p1 <= rr1;
      rr2_p1 <= rr2;
      rd_p1  <= rd_dec;
      imm_p1 <= imm_dec;
      tgt_p1 <= {tgt_sum[XLEN-1:1], 1'b0};
      dcr_p1 <= dcr_dec;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid  = vld_p1;
  assign out_pc     = pc_p1;
  assign out_rr1    = rr1_p1;
  assign out_rr2    = rr2_p1;
  assign out_rd     = rd_p1;
  assign out_imm    = imm_p1;
  assign out_target = tgt_p1;
  assign out_dcr    = dcr_p1;

endmodule

// File: tb/tb_stage_id_hs.sv
// Directed self-checking bench for stage_id_hs; expectations follow RV32M_EN.
module tb_stage_id_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst, in_pc;
  logic        flush;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [2:0]  fwd_valid, fwd_pending;
  logic [14:0] fwd_rd;
  logic [95:0] fwd_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_rr1, out_rr2, out_imm, out_target;
  logic [4:0]  out_rd;
  logic [23:0] out_dcr;

  logic [31:0] rf [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  stage_id_hs dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .fwd_pending(fwd_pending), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rr1(out_rr1), .out_rr2(out_rr2), .out_rd(out_rd),
    .out_imm(out_imm), .out_target(out_target), .out_dcr(out_dcr)
  );

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic clear_fwd();
    fwd_valid = '0; fwd_pending = '0; fwd_rd = '0; fwd_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    in_inst = enc_i(12'd7, 5'd0, 3'd0, 5'd3, 7'b0010011); in_pc = 32'h44;
    step(); step();
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", out_valid); end
    checks++;
    if ({out_pc, out_rr1, out_rr2, out_imm, out_target} !== 160'd0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h %h exp 0", out_pc, out_rr1, out_rr2, out_imm, out_target);
    end
    checks++;
    if ({out_rd, out_dcr} !== 29'd0) begin errors++; $display("FAIL reset_rd_dcr got %h %h exp 0", out_rd, out_dcr); end
    checks++;
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    step();
  endtask

  task automatic test_decode();
    issue(enc_i(12'hFFD, 5'd2, 3'd0, 5'd1, 7'b0010011), 32'h10);
    if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_rd !== 5'd1) begin
      errors++; $display("FAIL addi_hdr got v=%h pc=%h rd=%h exp 1 10 1", out_valid, out_pc, out_rd);
    end
    checks++;
    if (out_imm !== 32'hFFFFFFFD || out_dcr !== 24'h04000C) begin
      errors++; $display("FAIL addi_imm_dcr got %h %h exp fffffffd 04000c", out_imm, out_dcr);
    end
    checks++;
    if (out_rr1 !== 32'h1002 || out_rr2 !== 32'h101D) begin
      errors++; $display("FAIL addi_rr got %h %h exp 1002 101d", out_rr1, out_rr2);
    end
    checks++;
    issue(enc_s(12'd12, 5'd5, 5'd6, 3'd2), 32'h14);
    if (out_imm !== 32'd12 || out_dcr !== 24'h208006 || out_rd !== 5'd0) begin
      errors++; $display("FAIL sw got imm=%h dcr=%h rd=%h exp c 208006 0", out_imm, out_dcr, out_rd);
    end
    checks++;
    issue(enc_r(7'b0100000, 5'd5, 5'd4, 3'd0, 5'd3), 32'h18);
    if (out_dcr !== 24'h08004E || out_rd !== 5'd3 || out_imm !== 32'd0) begin
      errors++; $display("FAIL sub got dcr=%h rd=%h imm=%h exp 08004e 3 0", out_dcr, out_rd, out_imm);
    end
    checks++;
    issue(enc_r(7'b0100000, 5'd5, 5'd4, 3'd5, 5'd3), 32'h1C);
    if (out_dcr !== 24'h58022E) begin errors++; $display("FAIL sra got %h exp 58022e", out_dcr); end
    checks++;
    issue(enc_u(20'h12345, 5'd7, 7'b0110111), 32'h20);
    if (out_imm !== 32'h12345000 || out_dcr !== 24'h004009 || out_rd !== 5'd7) begin
      errors++; $display("FAIL lui got imm=%h dcr=%h rd=%h exp 12345000 004009 7", out_imm, out_dcr, out_rd);
    end
    checks++;
    issue(32'hFFFFFFFF, 32'h24);
    if (out_valid !== 1'b1 || out_dcr !== 24'h000400 || out_rd !== 5'd0) begin
      errors++; $display("FAIL illegal got v=%h dcr=%h rd=%h exp 1 000400 0", out_valid, out_dcr, out_rd);
    end
    checks++;
    step();
  endtask

  task automatic test_load_use();
    issue(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'b0010011), 32'h20);
    fwd_valid = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd1}; fwd_pending = 3'b001;
    in_valid = 1'b1; in_inst = enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd2); in_pc = 32'h24;
    #1;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_ready got %h exp 0", in_ready); end
    checks++;
    step();
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %h exp 0", out_valid); end
    checks++;
    fwd_pending = 3'b000; fwd_data = {64'd0, 32'd5};
    #1;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release got %h exp 1", in_ready); end
    checks++;
    step();
    in_valid = 1'b0;
    if (out_valid !== 1'b1 || out_pc !== 32'h24 || out_rr1 !== 32'd5 || out_rr2 !== 32'd5) begin
      errors++; $display("FAIL lu_fwd got v=%h pc=%h rr1=%h rr2=%h exp 1 24 5 5", out_valid, out_pc, out_rr1, out_rr2);
    end
    checks++;
    clear_fwd();
    step();
  endtask

  task automatic test_fwd_priority();
    fwd_valid = 3'b111; fwd_rd = {5'd3, 5'd3, 5'd3}; fwd_data = {32'hC, 32'hB, 32'hA};
    issue(enc_r(7'd0, 5'd0, 5'd3, 3'd0, 5'd4), 32'h40);
    if (out_rr1 !== 32'hA || out_rr2 !== 32'd0) begin
      errors++; $display("FAIL fwd_src0 got %h %h exp a 0", out_rr1, out_rr2);
    end
    checks++;
    fwd_valid = 3'b110;
    issue(enc_r(7'd0, 5'd0, 5'd3, 3'd0, 5'd4), 32'h44);
    if (out_rr1 !== 32'hB) begin errors++; $display("FAIL fwd_src1 got %h exp b", out_rr1); end
    checks++;
    fwd_valid = 3'b000;
    issue(enc_r(7'd0, 5'd0, 5'd3, 3'd0, 5'd4), 32'h48);
    if (out_rr1 !== 32'h1003) begin errors++; $display("FAIL fwd_rf got %h exp 1003", out_rr1); end
    checks++;
    fwd_valid = 3'b001; fwd_rd = {5'd3, 5'd3, 5'd0}; fwd_data = {32'hC, 32'hB, 32'hDEAD};
    issue(enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd4), 32'h4C);
    if (out_rr1 !== 32'd0 || out_rr2 !== 32'd0) begin
      errors++; $display("FAIL fwd_x0 got %h %h exp 0 0", out_rr1, out_rr2);
    end
    checks++;
    // Younger non-pending match shadows an older pending one.
    fwd_valid = 3'b011; fwd_rd = {5'd0, 5'd3, 5'd3}; fwd_pending = 3'b010;
    fwd_data = {32'hC, 32'hB, 32'hA};
    in_valid = 1'b1; in_inst = enc_r(7'd0, 5'd0, 5'd3, 3'd0, 5'd4); in_pc = 32'h50;
    #1;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL fwd_shadow_ready got %h exp 1", in_ready); end
    checks++;
    step();
    in_valid = 1'b0;
    if (out_rr1 !== 32'hA || out_pc !== 32'h50) begin
      errors++; $display("FAIL fwd_shadow got %h pc=%h exp a 50", out_rr1, out_pc);
    end
    checks++;
    // LUI has no rs1 even when its immediate bits alias a pending register.
    fwd_valid = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd3}; fwd_pending = 3'b001;
    in_valid = 1'b1; in_inst = enc_u(20'h00018, 5'd9, 7'b0110111); in_pc = 32'h54;
    #1;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL lui_nostall got %h exp 1", in_ready); end
    checks++;
    step();
    in_valid = 1'b0;
    clear_fwd();
    step();
  endtask

  task automatic test_back_to_back();
    int sent = 0, recv = 0, cyc = 0;
    logic held = 1'b0, acc;
    logic [31:0] s_pc, s_imm, s_rr2;
    logic [23:0] s_dcr;
    while (recv < 8 && cyc < 40) begin
      out_ready = !(cyc >= 2 && cyc < 6);
      in_valid  = (sent < 8);
      in_inst   = enc_i(12'(sent + 1), 5'd0, 3'd0, 5'(sent + 1), 7'b0010011);
      in_pc     = 32'h200 + 32'(4 * sent);
      #1;
      if (out_valid && out_ready) begin
        if (out_pc !== 32'h200 + 32'(4 * recv) || out_imm !== 32'(recv + 1) ||
            out_rd !== 5'(recv + 1) || out_rr2 !== 32'h1000 + 32'(recv + 1)) begin
          errors++; $display("FAIL b2b_order got pc=%h imm=%h rd=%h rr2=%h exp index %0d", out_pc, out_imm, out_rd, out_rr2, recv);
        end
        checks++;
        recv++;
      end
      if (out_valid && !out_ready) begin
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got %h exp 0", in_ready); end
        checks++;
        if (held) begin
          if (out_pc !== s_pc || out_imm !== s_imm || out_rr2 !== s_rr2 || out_dcr !== s_dcr) begin
            errors++; $display("FAIL b2b_hold got pc=%h imm=%h exp pc=%h imm=%h", out_pc, out_imm, s_pc, s_imm);
          end
          checks++;
        end
        s_pc = out_pc; s_imm = out_imm; s_rr2 = out_rr2; s_dcr = out_dcr; held = 1'b1;
      end else begin
        held = 1'b0;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
      #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    if (recv != 8 || sent != 8) begin errors++; $display("FAIL b2b_count got sent=%0d recv=%0d exp 8 8", sent, recv); end
    checks++;
    step();
  endtask

  task automatic test_flush();
    issue(enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'b0010011), 32'h300);
    if (out_valid !== 1'b1 || out_pc !== 32'h300) begin
      errors++; $display("FAIL flush_pre got v=%h pc=%h exp 1 300", out_valid, out_pc);
    end
    checks++;
    in_valid = 1'b1; in_inst = enc_i(12'd2, 5'd0, 3'd0, 5'd2, 7'b0010011); in_pc = 32'h304;
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill got %h exp 0", out_valid); end
    checks++;
    step();
    if (out_valid !== 1'b0 || out_pc === 32'h304) begin
      errors++; $display("FAIL flush_leak got v=%h pc=%h exp 0 not 304", out_valid, out_pc);
    end
    checks++;
    issue(enc_i(12'd3, 5'd0, 3'd0, 5'd3, 7'b0010011), 32'h308);
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_pc = 32'h30C;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_hold got %h exp 0", out_valid); end
    checks++;
    step();
  endtask

  task automatic test_targets();
    rf[10] = 32'h2003;
    issue(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0), 32'h100);
    if (out_target !== 32'hF8 || out_imm !== 32'hFFFFFFF8) begin
      errors++; $display("FAIL tgt_beq got %h imm=%h exp f8 fffffff8", out_target, out_imm);
    end
    checks++;
    issue(enc_i(12'd4, 5'd10, 3'd0, 5'd1, 7'b1100111), 32'h104);
    if (out_target !== 32'h2006 || out_rd !== 5'd1) begin
      errors++; $display("FAIL tgt_jalr got %h rd=%h exp 2006 1", out_target, out_rd);
    end
    checks++;
    issue(enc_u(20'h00001, 5'd5, 7'b0010111), 32'h400);
    if (out_target !== 32'h1400 || out_imm !== 32'h1000 || out_dcr !== 24'h804008) begin
      errors++; $display("FAIL tgt_auipc got %h imm=%h dcr=%h exp 1400 1000 804008", out_target, out_imm, out_dcr);
    end
    checks++;
    issue(enc_j(21'h20, 5'd1), 32'h104);
    if (out_target !== 32'h124 || out_imm !== 32'h20 || out_dcr !== 24'h001008) begin
      errors++; $display("FAIL tgt_jal got %h imm=%h dcr=%h exp 124 20 001008", out_target, out_imm, out_dcr);
    end
    checks++;
    rf[10] = 32'h100A;
    step();
  endtask

  task automatic test_rv32m();
    issue(enc_r(7'b0000001, 5'd7, 5'd6, 3'd0, 5'd5), 32'h600);
`ifdef RV32M_EN
    if (out_dcr !== 24'h08080E || out_rd !== 5'd5) begin
      errors++; $display("FAIL mul got dcr=%h rd=%h exp 08080e 5", out_dcr, out_rd);
    end
`else
    if (out_dcr !== 24'h000400 || out_rd !== 5'd0) begin
      errors++; $display("FAIL mul got dcr=%h rd=%h exp 000400 0", out_dcr, out_rd);
    end
`endif
    checks++;
    step();
  endtask

  task automatic test_reset_mid_stall();
    issue(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'b0010011), 32'h500);
    out_ready = 1'b0;
    fwd_valid = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd1}; fwd_pending = 3'b001;
    in_valid = 1'b1; in_inst = enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd2); in_pc = 32'h504;
    #1;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_stall_pre got rdy=%h v=%h exp 0 1", in_ready, out_valid);
    end
    checks++;
    rst = 1'b1;
    step();
    if (out_valid !== 1'b0 || out_pc !== 32'd0) begin
      errors++; $display("FAIL rst_stall got v=%h pc=%h exp 0 0", out_valid, out_pc);
    end
    checks++;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    clear_fwd();
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : 32'h1000 + 32'(i);
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0;
    out_ready = 1'b1;
    clear_fwd();
    test_reset();
    test_decode();
    test_load_use();
    test_fwd_priority();
    test_back_to_back();
    test_flush();
    test_targets();
    test_rv32m();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
